mem_burst_slave: RTL and testbench

MEM_BURST_SLAVE -- requirements
Module: mem_burst_slave

---
 rtl/mem_burst_slave.sv | 218 +++++++++++++++++++++
 tb/tb_mem_burst_slave.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_slave.sv
// Burst memory slave with independent read and write channels.
// Read data is fetched at the handshake edge, so a same-cycle write to that address returns the old word.
module mem_burst_slave #(
    parameter int DW    = 8,
    parameter int AW    = 9,
    parameter int DEPTH = 256,
    parameter int IDW   = 4,
    parameter int LENW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ARVALID,
    output logic            ARREADY,
    input  logic [AW-1:0]   ARADDR,
    input  logic [LENW-1:0] ARLEN,
    input  logic [IDW-1:0]  ARID,
    output logic            RVALID,
    input  logic            RREADY,
    output logic [DW-1:0]   RDATA,
    output logic            RRESP,
    output logic            RLAST,
    output logic [IDW-1:0]  RID,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [AW-1:0]   AWADDR,
    input  logic [IDW-1:0]  AWID,
    input  logic            WVALID,
    output logic            WREADY,
    input  logic [DW-1:0]   WDATA,
    input  logic            WLAST,
    output logic            BVALID,
    input  logic            BREADY,
    output logic            BRESP,
    output logic [IDW-1:0]  BID
);

    localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Zero at power-up; deliberately untouched by reset.
    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    r_state_t        r_state, r_state_n;
    logic            arready_n, rvalid_n, rresp_n, rlast_n;
    logic [DW-1:0]   rdata_n;
    logic [IDW-1:0]  rid_n;
    logic [AW-1:0]   raddr, raddr_n, rd_addr;
    logic [LENW-1:0] rcnt, rcnt_n;
    logic            rd_load;

    w_state_t        w_state, w_state_n;
    logic            awready_n, wready_n, bvalid_n, bresp_n;
    logic [IDW-1:0]  bid_n, wid, wid_n;
    logic [AW-1:0]   waddr, waddr_n;
    logic            werr, werr_n, mem_we;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    always_comb begin
        r_state_n = r_state;
        arready_n = ARREADY;
        rvalid_n  = RVALID;
        rdata_n   = RDATA;
        rresp_n   = RRESP;
        rlast_n   = RLAST;
        rid_n     = RID;
        raddr_n   = raddr;
        rcnt_n    = rcnt;
        rd_addr   = raddr + AW'(1);
        rd_load   = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (ARVALID && ARREADY) begin
                    r_state_n = R_DATA;
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    raddr_n   = ARADDR;
                    rcnt_n    = ARLEN;
                    rid_n     = ARID;
                    rlast_n   = (ARLEN == '0);
                    rd_addr   = ARADDR;
                    rd_load   = 1'b1;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY) begin
                    if (RLAST) begin
                        r_state_n = R_IDLE;
                        arready_n = 1'b1;
                        rvalid_n  = 1'b0;
                        rdata_n   = '0;
                        rresp_n   = 1'b0;
                        rlast_n   = 1'b0;
                        rid_n     = '0;
                    end else begin
                        raddr_n = raddr + AW'(1);
                        rcnt_n  = rcnt - LENW'(1);
                        rlast_n = (rcnt == LENW'(1));
                        rd_load = 1'b1;
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
        if (rd_load) begin
            rresp_n = !in_range(rd_addr);
            rdata_n = in_range(rd_addr) ? mem[rd_addr[MAW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            raddr   <= '0;
            rcnt    <= '0;
        end else begin
            r_state <= r_state_n;
            ARREADY <= arready_n;
            RVALID  <= rvalid_n;
            RDATA   <= rdata_n;
            RRESP   <= rresp_n;
            RLAST   <= rlast_n;
            RID     <= rid_n;
            raddr   <= raddr_n;
            rcnt    <= rcnt_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        awready_n = AWREADY;
        wready_n  = WREADY;
        bvalid_n  = BVALID;
        bresp_n   = BRESP;
        bid_n     = BID;
        wid_n     = wid;
        waddr_n   = waddr;
        werr_n    = werr;
        mem_we    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (AWVALID && AWREADY) begin
                    w_state_n = W_DATA;
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    waddr_n   = AWADDR;
                    wid_n     = AWID;
                    werr_n    = 1'b0;
                end
            end
            W_DATA: begin
                if (WVALID && WREADY) begin
                    mem_we  = in_range(waddr);
                    waddr_n = waddr + AW'(1);
                    werr_n  = werr | !in_range(waddr);
                    if (WLAST) begin
                        w_state_n = W_RESP;
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bresp_n   = werr | !in_range(waddr);
                        bid_n     = wid;
                    end
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) begin
                    w_state_n = W_IDLE;
                    bvalid_n  = 1'b0;
                    bresp_n   = 1'b0;
                    bid_n     = '0;
                    awready_n = 1'b1;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= 1'b0;
            BID     <= '0;
            wid     <= '0;
            waddr   <= '0;
            werr    <= 1'b0;
        end else begin
            w_state <= w_state_n;
            AWREADY <= awready_n;
            WREADY  <= wready_n;
            BVALID  <= bvalid_n;
            BRESP   <= bresp_n;
            BID     <= bid_n;
            wid     <= wid_n;
            waddr   <= waddr_n;
            werr    <= werr_n;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr[MAW-1:0]] <= WDATA;
    end

endmodule

// File: tb/tb_mem_burst_slave.sv
// Directed bench for mem_burst_slave: bursts, stalls, out-of-range beats, wrap, mid-burst reset.
module tb_mem_burst_slave;

    logic       clk, rst;
    logic       ARVALID, ARREADY;
    logic [8:0] ARADDR;
    logic [3:0] ARLEN, ARID;
    logic       RVALID, RREADY, RRESP, RLAST;
    logic [7:0] RDATA;
    logic [3:0] RID;
    logic       AWVALID, AWREADY;
    logic [8:0] AWADDR;
    logic [3:0] AWID;
    logic       WVALID, WREADY, WLAST;
    logic [7:0] WDATA;
    logic       BVALID, BREADY, BRESP;
    logic [3:0] BID;

    int errors = 0;
    int checks = 0;

    logic [7:0] wd [4];
    logic [7:0] rexp_d [4];
    logic       rexp_r [4];

    mem_burst_slave #(.DW(8), .AW(9), .DEPTH(256), .IDW(4), .LENW(4)) dut (
        .clk(clk), .rst(rst),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [8:0] addr, input logic [3:0] id, input int n,
                               input logic exp_resp);
        bit ok = 0;
        AWVALID = 1'b1; AWADDR = addr; AWID = id;
        for (int c = 0; c < 16; c++) begin
            if (AWREADY) begin ok = 1; break; end
            tick();
        end
        if (!ok) check("aw_timeout", 32'(AWREADY), 32'd1);
        tick();
        AWVALID = 1'b0;
        for (int i = 0; i < n; i++) begin
            WVALID = 1'b1; WDATA = wd[i]; WLAST = (i == n - 1);
            check("wready", 32'(WREADY), 32'd1);
            tick();
        end
        WVALID = 1'b0; WLAST = 1'b0;
        check("bvalid", 32'(BVALID), 32'd1);
        check("bresp", 32'(BRESP), 32'(exp_resp));
        check("bid", 32'(BID), 32'(id));
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_drop", 32'(BVALID), 32'd0);
        check("awready_back", 32'(AWREADY), 32'd1);
    endtask

    task automatic read_burst(input logic [8:0] addr, input logic [3:0] len, input logic [3:0] id,
                              input logic [3:0] pat);
        bit ok = 0;
        int b = 0;
        int c = 0;
        ARVALID = 1'b1; ARADDR = addr; ARLEN = len; ARID = id;
        for (int k = 0; k < 16; k++) begin
            if (ARREADY) begin ok = 1; break; end
            tick();
        end
        if (!ok) check("ar_timeout", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
        while (b <= int'(len) && c < 64) begin
            check("rvalid", 32'(RVALID), 32'd1);
            check("rdata", 32'(RDATA), 32'(rexp_d[b]));
            check("rresp", 32'(RRESP), 32'(rexp_r[b]));
            check("rlast", 32'(RLAST), 32'(b == int'(len)));
            check("rid", 32'(RID), 32'(id));
            RREADY = pat[c % 4];
            tick();
            if (RREADY) b++;
            c++;
        end
        RREADY = 1'b0;
        if (b <= int'(len)) check("r_timeout", 32'(b), 32'(len) + 32'd1);
        check("rvalid_drop", 32'(RVALID), 32'd0);
        check("arready_back", 32'(ARREADY), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        ARVALID = 0; ARADDR = '0; ARLEN = '0; ARID = '0; RREADY = 0;
        AWVALID = 0; AWADDR = '0; AWID = '0; WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 0;

        // Reset state and ready timing after release
        #3;
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_wready", 32'(WREADY), 32'd0);
        tick(); tick();
        rst = 1'b1;
        check("arready_pre_edge", 32'(ARREADY), 32'd0);
        tick();
        check("arready_post_rst", 32'(ARREADY), 32'd1);
        check("awready_post_rst", 32'(AWREADY), 32'd1);

        // 4-beat write then full-speed and stalled reads
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        write_burst(9'h010, 4'd3, 4, 1'b0);
        rexp_d[0] = 8'h11; rexp_d[1] = 8'h22; rexp_d[2] = 8'h33; rexp_d[3] = 8'h44;
        rexp_r[0] = 0; rexp_r[1] = 0; rexp_r[2] = 0; rexp_r[3] = 0;
        read_burst(9'h010, 4'd3, 4'd5, 4'b1111);
        read_burst(9'h010, 4'd3, 4'd5, 4'b1001);

        // Untouched word reads as zero
        rexp_d[0] = 8'h00; rexp_r[0] = 0;
        read_burst(9'h000, 4'd0, 4'd7, 4'b1111);

        // Write crossing DEPTH: only first beat lands
        wd[0] = 8'hA5; wd[1] = 8'h5A; wd[2] = 8'hC3;
        write_burst(9'h0FF, 4'd9, 3, 1'b1);
        rexp_d[0] = 8'hA5; rexp_r[0] = 0; rexp_d[1] = 8'h00; rexp_r[1] = 1;
        read_burst(9'h0FF, 4'd1, 4'd2, 4'b1111);

        // Read wrapping from top of address space
        rexp_d[0] = 8'h00; rexp_r[0] = 1; rexp_d[1] = 8'h00; rexp_r[1] = 0;
        read_burst(9'h1FF, 4'd1, 4'd4, 4'b1111);
        wd[0] = 8'h77; wd[1] = 8'h88;
        write_burst(9'h1FF, 4'd6, 2, 1'b1);
        rexp_d[0] = 8'h00; rexp_r[0] = 1; rexp_d[1] = 8'h88; rexp_r[1] = 0;
        read_burst(9'h1FF, 4'd1, 4'd4, 4'b1111);

        // Reset in the middle of a read burst
        ARVALID = 1'b1; ARADDR = 9'h010; ARLEN = 4'd3; ARID = 4'd5;
        check("mid_arready", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0; RREADY = 1'b1;
        check("mid_beat1", 32'(RDATA), 32'h11);
        tick();
        check("mid_beat2", 32'(RDATA), 32'h22);
        rst = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(RVALID), 32'd0);
        check("mid_rst_rdata", 32'(RDATA), 32'd0);
        check("mid_rst_arready", 32'(ARREADY), 32'd0);
        RREADY = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("mid_arready_pre", 32'(ARREADY), 32'd0);
        tick();
        check("mid_arready_post", 32'(ARREADY), 32'd1);
        rexp_d[0] = 8'h11; rexp_d[1] = 8'h22; rexp_d[2] = 8'h33; rexp_d[3] = 8'h44;
        rexp_r[0] = 0; rexp_r[1] = 0; rexp_r[2] = 0; rexp_r[3] = 0;
        read_burst(9'h010, 4'd3, 4'd5, 4'b1111);

        // Same-cycle read and write of one address returns old data
        AWVALID = 1'b1; AWADDR = 9'h010; AWID = 4'd1;
        check("rbw_awready", 32'(AWREADY), 32'd1);
        tick();
        AWVALID = 1'b0;
        ARVALID = 1'b1; ARADDR = 9'h010; ARLEN = 4'd0; ARID = 4'd2;
        WVALID = 1'b1; WDATA = 8'h99; WLAST = 1'b1;
        check("rbw_arready", 32'(ARREADY), 32'd1);
        check("rbw_wready", 32'(WREADY), 32'd1);
        tick();
        ARVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
        check("rbw_rvalid", 32'(RVALID), 32'd1);
        check("rbw_rdata_old", 32'(RDATA), 32'h11);
        check("rbw_rlast", 32'(RLAST), 32'd1);
        check("rbw_rid", 32'(RID), 32'd2);
        check("rbw_bvalid", 32'(BVALID), 32'd1);
        check("rbw_bresp", 32'(BRESP), 32'd0);
        check("rbw_bid", 32'(BID), 32'd1);
        RREADY = 1'b1; BREADY = 1'b1;
        tick();
        RREADY = 1'b0; BREADY = 1'b0;
        check("rbw_rvalid_drop", 32'(RVALID), 32'd0);
        check("rbw_bvalid_drop", 32'(BVALID), 32'd0);
        rexp_d[0] = 8'h99; rexp_r[0] = 0;
        read_burst(9'h010, 4'd0, 4'd8, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
